// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device sender: state encoding,
// timing defaults and frame bit positions.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_START   = 3'd2,
        ST_BITS    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } ps2_state_e;

    localparam int unsigned INHIBIT_DEF = 800;
    localparam int unsigned TIMEOUT_DEF = 16000;

    localparam logic [3:0] LAST_DATA_EDGE = 4'd8;
    localparam logic [3:0] PARITY_EDGE    = 4'd9;
    localparam logic [3:0] STOP_EDGE      = 4'd10;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_send_if.sv
// Signal bundle between a host-side user and the PS/2 sender, plus the raw
// PS/2 line levels and open-drain enables.
interface ps2_send_if;
    // req is a one-cycle strobe, taken only while busy=0 (never queued);
    // done/err are one-cycle completion strobes, coincident with busy falling.
    logic       req;
    logic [7:0] di;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2ClkI;
    logic       ps2DatI;
    logic       ps2ClkOe;
    logic       ps2DatOe;

    modport master (
        output req, di, ps2ClkI, ps2DatI,
        input  busy, done, err, ps2ClkOe, ps2DatOe
    );

    modport slave (
        input  req, di, ps2ClkI, ps2DatI,
        output busy, done, err, ps2ClkOe, ps2DatOe
    );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous line, with a falling-edge
// detector that compares consecutive ce-qualified samples.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic din,
    output logic sync,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle PS/2 lines are high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            if (ce) prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign fall = ce & prev_q & ~sync_q;
endmodule

// File: rtl/ps2_send.sv
// PS/2 host-to-device byte sender. Define PS2_SEND_TIMEOUT_EN to add a
// watchdog that aborts a transfer when the device stops clocking.
module ps2_send
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT = INHIBIT_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    ps2_send_if.slave   bus,
    output ps2_state_e  state_dbg
);
    localparam int INH_W = $clog2(INHIBIT + 1);

    ps2_state_e       state, state_n;
    logic [7:0]       data_q, data_n;
    logic             parity_q, parity_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic             done_q, done_n;
    logic             err_q, err_n;
    logic             clk_oe, dat_oe;
    logic             clk_sync, clk_fall;
    logic             dat_meta, dat_sync;
    logic [2:0]       bit_idx;

`ifdef PS2_SEND_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_n;
`endif

    ps2_sync_edge u_clk_sync (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .din   (bus.ps2ClkI),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    // Data needs no edge detection; it is only sampled on clock edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= bus.ps2DatI;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_SEND_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            state    <= state_n;
            data_q   <= data_n;
            parity_q <= parity_n;
            bit_cnt  <= bit_cnt_n;
            inh_cnt  <= inh_cnt_n;
            done_q   <= done_n;
            err_q    <= err_n;
`ifdef PS2_SEND_TIMEOUT_EN
            wd_cnt   <= wd_cnt_n;
`endif
        end
    end

    // bit_cnt n (1..8) presents data bit n-1 on the line.
    assign bit_idx = 3'(bit_cnt - 4'd1);

    always_comb begin
        state_n   = state;
        data_n    = data_q;
        parity_n  = parity_q;
        bit_cnt_n = bit_cnt;
        inh_cnt_n = inh_cnt;
        done_n    = 1'b0;
        err_n     = 1'b0;
        clk_oe    = 1'b0;
        dat_oe    = 1'b0;
`ifdef PS2_SEND_TIMEOUT_EN
        wd_cnt_n  = '0;
`endif

        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    data_n    = bus.di;
                    parity_n  = odd_parity(bus.di);
                    bit_cnt_n = '0;
                    inh_cnt_n = '0;
                    state_n   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                clk_oe = 1'b1;
                if (ce) begin
                    if (inh_cnt == INH_W'(INHIBIT - 1)) state_n = ST_START;
                    else inh_cnt_n = inh_cnt + INH_W'(1);
                end
            end
            ST_START: begin
                dat_oe  = 1'b1;
                state_n = ST_BITS;
            end
            ST_BITS: begin
                // Count 0 still holds the start bit; count 10 is the released stop bit.
                if (bit_cnt == 4'd0)                 dat_oe = 1'b1;
                else if (bit_cnt <= LAST_DATA_EDGE)  dat_oe = ~data_q[bit_idx];
                else if (bit_cnt == PARITY_EDGE)     dat_oe = ~parity_q;
                if (clk_fall) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == PARITY_EDGE) state_n = ST_ACK;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!dat_sync) begin
                        state_n = ST_RELEASE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_RELEASE: begin
                if (ce && clk_sync && dat_sync) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

`ifdef PS2_SEND_TIMEOUT_EN
        if (state inside {ST_START, ST_BITS, ST_ACK, ST_RELEASE}) begin
            if (clk_fall) begin
                wd_cnt_n = '0;
            end else if (ce) begin
                if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b0;
                    err_n   = 1'b1;
                    clk_oe  = 1'b0;
                    dat_oe  = 1'b0;
                end else begin
                    wd_cnt_n = wd_cnt + WD_W'(1);
                end
            end else begin
                wd_cnt_n = wd_cnt;
            end
        end
`endif
    end

    assign bus.ps2ClkOe = clk_oe;
    assign bus.ps2DatOe = dat_oe;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign state_dbg    = state;
endmodule
